instr_fetch_stage: RTL and testbench

- Fetch stage of the RV32 pipeline. Sits directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned byte address into instruction memory. Instruction memory returns data combinationally in the same cycle.
- Registers pc, instruction and pc+4 into the IF/ID pipeline register.
- Handles stall from hazard logic and redirect (branch/jump/trap) from execute.

---
 rtl/instr_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// RV32 fetch stage: owns the pc, addresses instruction memory and registers pc/pc+4/instr into IF/ID.
// Optional macro IFETCH_MISALIGN_CHK_EN keeps misaligned redirect targets and flags them instead of masking.
module instr_fetch_stage #(
    parameter int unsigned ADDR_W   = 13,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              if_id_valid_o,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_misalign_o,
    output logic [31:0]       fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misal_q, misal_d;     // sticky: pc points at a misaligned target
    logic id_misal_q, id_misal_d;
    assign redirect_tgt = redirect_pc_i;
`else
    assign redirect_tgt = redirect_pc_i & ~32'h3;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
`ifdef IFETCH_MISALIGN_CHK_EN
        misal_d    = misal_q;
        id_misal_d = id_misal_q;
`endif
        if (redirect_i) begin
            // The fetch currently at imem is squashed; the target is fetched in S_REDIR.
            pc_d    = redirect_tgt;
            valid_d = 1'b0;
            instr_d = NOP_INSN;
            state_d = S_REDIR;
`ifdef IFETCH_MISALIGN_CHK_EN
            misal_d    = (redirect_tgt[1:0] != 2'b00);
            id_misal_d = 1'b0;
`endif
        end else if (!stall_i) begin
            state_d = S_RUN;
            if (state_q == S_BOOT) begin
                valid_d = 1'b0;
                instr_d = NOP_INSN;
`ifdef IFETCH_MISALIGN_CHK_EN
                id_misal_d = 1'b0;
            end else if (misal_q) begin
                // Deliver the faulting entry once, then park on bubbles until a new redirect.
                id_misal_d = (state_q == S_REDIR);
                valid_d    = (state_q == S_REDIR);
                instr_d    = NOP_INSN;
                id_pc_d    = pc_q;
                id_pc4_d   = pc_plus4;
                if (state_q == S_REDIR) begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end else begin
                pc_d     = pc_plus4;
                valid_d  = 1'b1;
                id_pc_d  = pc_q;
                id_pc4_d = pc_plus4;
                instr_d  = imem_data_i;
                cnt_d    = cnt_q + 32'd1;
`ifdef IFETCH_MISALIGN_CHK_EN
                id_misal_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            id_pc_q  <= RESET_PC;
            id_pc4_q <= RESET_PC + 32'd4;
            instr_q  <= NOP_INSN;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misal_q    <= 1'b0;
            id_misal_q <= 1'b0;
        end else begin
            misal_q    <= misal_d;
            id_misal_q <= id_misal_d;
        end
    end
    assign if_id_misalign_o = id_misal_q;
`else
    assign if_id_misalign_o = 1'b0;
`endif

    assign imem_addr_o   = pc_q[ADDR_W-1:0];
    assign if_id_valid_o = valid_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_pc4_o   = id_pc4_q;
    assign if_id_instr_o = instr_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; memory returns 0xA000_0000 | byte address.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_misalign;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'hA000_0000 | {19'd0, imem_addr};

    instr_fetch_stage #(
        .ADDR_W  (13),
        .RESET_PC(32'h0000_0000),
        .NOP_INSN(32'h0000_0013)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .if_id_valid_o   (if_id_valid),
        .if_id_pc_o      (if_id_pc),
        .if_id_pc4_o     (if_id_pc4),
        .if_id_instr_o   (if_id_instr),
        .if_id_misalign_o(if_id_misalign),
        .fetch_cnt_o     (fetch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", if_id_pc); end
        checks++; if (if_id_pc4 !== 32'h4) begin failures++; $display("FAIL rst_pc4 got=%h exp=00000004", if_id_pc4); end
        checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", if_id_instr); end
        checks++; if (if_id_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%0h exp=0", if_id_misalign); end
        checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", fetch_cnt); end
        checks++; if (imem_addr !== 13'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_boot();
        tick();
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL boot_e1_valid got=%0h exp=0", if_id_valid); end
        tick();
        checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL boot_e2_valid got=%0h exp=1", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL boot_e2_pc got=%h exp=00000000", if_id_pc); end
        checks++; if (if_id_instr !== 32'hA000_0000) begin failures++; $display("FAIL boot_e2_instr got=%h exp=a0000000", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'h4) begin failures++; $display("FAIL boot_e2_pc4 got=%h exp=00000004", if_id_pc4); end
        tick();
        checks++; if (if_id_pc !== 32'h4) begin failures++; $display("FAIL boot_e3_pc got=%h exp=00000004", if_id_pc); end
        checks++; if (if_id_instr !== 32'hA000_0004) begin failures++; $display("FAIL boot_e3_instr got=%h exp=a0000004", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd2) begin failures++; $display("FAIL boot_e3_cnt got=%0d exp=2", fetch_cnt); end
    endtask

    task automatic test_stall();
        tick();
        tick();
        checks++; if (imem_addr !== 13'h10) begin failures++; $display("FAIL stall_pre_addr got=%h exp=0010", imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 13'h10) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=0010", i, imem_addr); end
            checks++; if (if_id_pc !== 32'hC) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=0000000c", i, if_id_pc); end
            checks++; if (fetch_cnt !== 32'd4) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=4", i, fetch_cnt); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_id_pc !== 32'h10) begin failures++; $display("FAIL stall_rel_pc got=%h exp=00000010", if_id_pc); end
        checks++; if (if_id_instr !== 32'hA000_0010) begin failures++; $display("FAIL stall_rel_instr got=%h exp=a0000010", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd5) begin failures++; $display("FAIL stall_rel_cnt got=%0d exp=5", fetch_cnt); end
    endtask

    task automatic test_redirect();
        tick();
        tick();
        tick();
        checks++; if (imem_addr !== 13'h20) begin failures++; $display("FAIL redir_pre_addr got=%h exp=0020", imem_addr); end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble_valid got=%0h exp=0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL redir_bubble_instr got=%h exp=00000013", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd8) begin failures++; $display("FAIL redir_bubble_cnt got=%0d exp=8", fetch_cnt); end
        tick();
        checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL redir_tgt_valid got=%0h exp=1", if_id_valid); end
        checks++; if (if_id_pc !== 32'h100) begin failures++; $display("FAIL redir_tgt_pc got=%h exp=00000100", if_id_pc); end
        checks++; if (if_id_pc4 !== 32'h104) begin failures++; $display("FAIL redir_tgt_pc4 got=%h exp=00000104", if_id_pc4); end
        checks++; if (if_id_instr !== 32'hA000_0100) begin failures++; $display("FAIL redir_tgt_instr got=%h exp=a0000100", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd9) begin failures++; $display("FAIL redir_tgt_cnt got=%0d exp=9", fetch_cnt); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rs_bubble_valid got=%0h exp=0", if_id_valid); end
        checks++; if (imem_addr !== 13'h40) begin failures++; $display("FAIL rs_addr got=%h exp=0040", imem_addr); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rs_hold_valid got=%0h exp=0", if_id_valid); end
        checks++; if (fetch_cnt !== 32'd9) begin failures++; $display("FAIL rs_hold_cnt got=%0d exp=9", fetch_cnt); end
        stall = 1'b0;
        tick();
        checks++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin failures++; $display("FAIL rs_tgt pc=%h valid=%0h exp pc=00000040 valid=1", if_id_pc, if_id_valid); end
        checks++; if (fetch_cnt !== 32'd10) begin failures++; $display("FAIL rs_tgt_cnt got=%0d exp=10", fetch_cnt); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 13'h1FFC) begin failures++; $display("FAIL wrap_addr got=%h exp=1ffc", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", if_id_pc); end
        checks++; if (if_id_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=00000000", if_id_pc4); end
        checks++; if (if_id_instr !== 32'hA000_1FFC) begin failures++; $display("FAIL wrap_instr got=%h exp=a0001ffc", if_id_instr); end
        checks++; if (imem_addr !== 13'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=0000", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL wrap_next_pc got=%h exp=00000000", if_id_pc); end
        checks++; if (fetch_cnt !== 32'd12) begin failures++; $display("FAIL wrap_cnt got=%0d exp=12", fetch_cnt); end
    endtask

    task automatic test_misalign();
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL mis_bubble_valid got=%0h exp=0", if_id_valid); end
`ifdef IFETCH_MISALIGN_CHK_EN
        checks++; if (imem_addr !== 13'h102) begin failures++; $display("FAIL mis_addr got=%h exp=0102", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 32'h102 || if_id_valid !== 1'b1) begin failures++; $display("FAIL mis_pc pc=%h valid=%0h exp pc=00000102 valid=1", if_id_pc, if_id_valid); end
        checks++; if (if_id_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0h exp=1", if_id_misalign); end
        checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL mis_instr got=%h exp=00000013", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd13) begin failures++; $display("FAIL mis_cnt got=%0d exp=13", fetch_cnt); end
        tick();
        checks++; if (imem_addr !== 13'h102) begin failures++; $display("FAIL mis_hold_addr got=%h exp=0102", imem_addr); end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (if_id_pc !== 32'h200 || if_id_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear pc=%h flag=%0h exp pc=00000200 flag=0", if_id_pc, if_id_misalign); end
`else
        checks++; if (imem_addr !== 13'h100) begin failures++; $display("FAIL mis_addr got=%h exp=0100", imem_addr); end
        tick();
        checks++; if (if_id_pc !== 32'h100) begin failures++; $display("FAIL mis_pc got=%h exp=00000100", if_id_pc); end
        checks++; if (if_id_misalign !== 1'b0) begin failures++; $display("FAIL mis_flag got=%0h exp=0", if_id_misalign); end
        checks++; if (if_id_instr !== 32'hA000_0100) begin failures++; $display("FAIL mis_instr got=%h exp=a0000100", if_id_instr); end
        checks++; if (fetch_cnt !== 32'd13) begin failures++; $display("FAIL mis_cnt got=%0d exp=13", fetch_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0h exp=0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin failures++; $display("FAIL arst_pc pc=%h pc4=%h exp 00000000/00000004", if_id_pc, if_id_pc4); end
        checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL arst_instr got=%h exp=00000013", if_id_instr); end
        checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", fetch_cnt); end
        checks++; if (imem_addr !== 13'h0 || if_id_misalign !== 1'b0) begin failures++; $display("FAIL arst_addr addr=%h flag=%0h exp 0000/0", imem_addr, if_id_misalign); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL arst_boot_valid got=%0h exp=0", if_id_valid); end
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin failures++; $display("FAIL arst_first valid=%0h pc=%h exp 1/00000000", if_id_valid, if_id_pc); end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_misalign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
